apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB initiator that turns a queued command stream (read/write, address, data) into APB3 transfers.
- Returns one response per command: read data plus error/timeout flags.
- Sits between a sequencer or host-side bridge and APB-slave register blocks such as the CC1200 SPI register file. Used to program and poll them without a CPU.
- Commands are buffered in a small FIFO. Transfers are strictly one at a time and in order.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT, 255, maximum ACCESS-phase cycles without pready before abort; range 1..65535.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  APB address
- cmd_wdata  in  32  write data; ignored for reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_err  out  1  pslverr sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  FIFO not empty or FSM not in IDLE
- m_paddr  out  32  APB paddr
- m_psel  out  1  APB psel
- m_penable  out  1  APB penable
- m_pwrite  out  1  APB pwrite
- m_pwdata  out  32  APB pwdata
- m_prdata  in  32  APB prdata
- m_pready  in  1  APB pready
- m_pslverr  in  1  APB pslverr

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. FIFO emptied, FSM to IDLE, timeout counter cleared. Reset applies immediately, including mid-transfer; an in-flight command and any pending response are discarded.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - Push and pop on the same edge are allowed and leave the level unchanged.
  - When full, cmd_ready=0 and cmd_valid is ignored.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - psel=0, penable=0.
  - If FIFO not empty, pop the head, latch addr/wdata/write into m_paddr/m_pwdata/m_pwrite, go to SETUP.
- SETUP: psel=1, penable=0. Lasts exactly one cycle, then ACCESS. Timeout counter cleared.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite and pwdata stay stable from SETUP until the transfer completes.
  - Completes on the first edge with m_pready=1: capture m_prdata (reads only, else 0) and m_pslverr into rsp_err, set rsp_timeout=0, go to RESP.
  - Otherwise increment the counter. If the counter reaches TIMEOUT-1 with no pready, go to RESP with rsp_timeout=1, rsp_err=1, rsp_rdata=0. The ACCESS phase therefore lasts at most TIMEOUT cycles.
- RESP:
  - psel=0, penable=0, rsp_valid=1.
  - rsp_* held stable until rsp_ready. Leave on rsp_valid && rsp_ready, to IDLE.
  - No new transfer starts while a response is pending.
- m_pready and m_pslverr are ignored outside ACCESS. A slave with registered pready may leave it high one cycle after the transfer; this must not complete the next transfer.
- At least one psel=0 cycle (RESP) separates consecutive transfers.
- Latency, zero-wait slave, rsp_ready held 1:
  - command accepted at edge E0
  - SETUP after E1
  - ACCESS after E2
  - RESP after E3
  - IDLE after E4
  - next SETUP after E5
- One-wait slave (pready registered from penable&&psel): RESP after E4.
- m_paddr/m_pwrite/m_pwdata keep their last values in IDLE/RESP; only psel qualifies them.
- busy=0 only when the FIFO is empty and the FSM is in IDLE.

Test Plan:
- Zero-wait slave, write addr 0x14 data 0x0000_0032 -> psel high 1 cycle after accept, penable the cycle after. Response after E3 with rsp_err=0, rsp_rdata=0. Slave register 0x14 reads back 0x32.
- Registered-pready slave, read addr 0x00 holding 0x5 -> ACCESS lasts 2 cycles, rsp_rdata=0x0000_0005. Stale pready after the transfer does not terminate the next queued read of 0x04.
- Five commands pushed back-to-back with rsp_ready=0, FIFO_DEPTH=4 -> first command goes to the FSM, four are queued. cmd_ready drops after the 5th accept. A 6th is refused until rsp_ready pulses, and order is preserved.
- Slave holds pready=0, TIMEOUT=8 -> penable high exactly 8 cycles. Response has rsp_timeout=1, rsp_err=1, rsp_rdata=0, and the next command proceeds normally.
- Slave returns pslverr=1 with pready on a read of 0x0C, prdata 0xDEADBEEF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEADBEEF.
- rstn asserted during ACCESS with two commands queued -> psel/penable drop immediately, cmd_ready=1, busy=0, rsp_valid=0. No transfer occurs after release until a new command arrives.

Source files
------------

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_master
// Description : APB3 initiator driven by a buffered command stream. Commands
//               (read/write, address, write data) are queued in a small FIFO
//               and executed strictly one at a time, in order. Each command
//               produces one response carrying read data and error/timeout
//               flags.
// Ports       : clk, rstn (async, active-low)
//               cmd_*  : command input, valid/ready handshake
//               rsp_*  : response output, valid/ready handshake
//               busy   : FIFO not empty or a transfer in progress
//               m_*    : APB3 master interface
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cmd_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [31:0] m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_pwdata,
    input  logic [31:0] m_prdata,
    input  logic        m_pready,
    input  logic        m_pslverr
);

    localparam int          PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // ------------------------------------------------------------------
    // Command FIFO: entry = {write, addr, wdata}. Pointers carry one extra
    // wrap bit so full and empty are distinguishable.
    // ------------------------------------------------------------------
    logic [64:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           fifo_empty;
    logic           fifo_full;
    logic           fifo_push;
    logic           fifo_pop;
    logic [64:0]    fifo_head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_push  = cmd_valid && !fifo_full;
    assign fifo_pop   = (state_q == S_IDLE) && !fifo_empty;
    assign fifo_head  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM and datapath registers
    // ------------------------------------------------------------------
    logic [15:0] tcnt_q, tcnt_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tout_q, tout_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            tcnt_q   <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tout_q   <= tout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tout_d   = tout_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pwrite_d = fifo_head[64];
                    paddr_d  = fifo_head[63:32];
                    pwdata_d = fifo_head[31:0];
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                tcnt_d  = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // pready is only honoured here, so a registered-pready slave
                // that leaves it high after completion cannot end a later
                // transfer early.
                if (m_pready) begin
                    rdata_d = pwrite_q ? 32'd0 : m_prdata;
                    err_d   = m_pslverr;
                    tout_d  = 1'b0;
                    state_d = S_RESP;
                end else if (tcnt_q == TO_LAST) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready   = !fifo_full;
    assign busy        = !fifo_empty || (state_q != S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tout_q;
    assign m_psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign m_penable   = (state_q == S_ACCESS);
    assign m_paddr     = paddr_q;
    assign m_pwrite    = pwrite_q;
    assign m_pwdata    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_cmd_master
// Description : Self-checking bench for apb_cmd_master with a behavioural
//               APB slave (zero-wait, registered-pready or stalling) and a
//               response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, busy;
    logic [31:0] m_paddr, m_pwdata, m_prdata;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;

    always #5 clk = ~clk;

    apb_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural APB slave ----------------
    int          mode     = 0;     // 0 zero-wait, 1 registered pready, 2 stall
    logic        err_mode = 1'b0;
    logic        s_init;
    logic        pready_r = 1'b0;
    logic [31:0] smem [16];
    logic [15:0] written;

    function automatic logic [31:0] init_val(int i);
        case (i)
            0:       return 32'h0000_0005;
            1:       return 32'h1111_0004;
            3:       return 32'hDEAD_BEEF;
            default: return 32'hA500_0000 | 32'(i);
        endcase
    endfunction

    always @(posedge clk) pready_r <= m_psel && m_penable;

    always @(posedge clk) begin
        if (s_init) begin
            written <= '0;
        end else if (m_psel && m_penable && m_pready && m_pwrite) begin
            smem[m_paddr[5:2]]    <= m_pwdata;
            written[m_paddr[5:2]] <= 1'b1;
        end
    end

    assign m_prdata  = written[m_paddr[5:2]] ? smem[m_paddr[5:2]] : init_val(int'(m_paddr[5:2]));
    assign m_pready  = (mode == 0) ? 1'b1 : (mode == 1) ? pready_r : 1'b0;
    assign m_pslverr = err_mode;

    // ---------------- reference memory (expected read data) ----------------
    logic [31:0] ref_mem [16];

    // ---------------- ACCESS-phase length monitor ----------------
    int cur_len  = 0;
    int last_len = 0;
    always @(negedge clk) begin
        if (m_psel && m_penable) cur_len <= cur_len + 1;
        else if (cur_len != 0) begin
            last_len <= cur_len;
            cur_len  <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        if (rstn && rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected got rdata=%h err=%b to=%b", rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
                    n_fail++;
                    $display("FAIL rsp_compare got rdata=%h err=%b to=%b expected rdata=%h err=%b to=%b",
                             rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
                end
            end
        end
    end

    // Offer one command and wait (bounded) until it is accepted; the expected
    // response is queued on acceptance. Entry/exit point: posedge + #1.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] er, input logic ee, input logic et);
        bit ok = 0;
        exp_t e;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
            @(posedge clk);
            if (ok) begin
                e.rdata = er; e.err = ee; e.to = et;
                exp_q.push_back(e);
            end
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept_timeout addr=%h never accepted", a);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, m_psel, m_penable, busy} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl got ready,rv,psel,pen,busy=%b expected 10000",
                     {cmd_ready, rsp_valid, m_psel, m_penable, busy});
        end
        n_checks++;
        if ({m_paddr, m_pwdata, rsp_rdata, m_pwrite, rsp_err, rsp_timeout} !== 99'd0) begin
            n_fail++;
            $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h expected all zero",
                     m_paddr, m_pwdata, rsp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_write();
        mode = 0; rsp_ready = 1'b1;
        send_cmd(1'b1, 32'h14, 32'h32, 32'h0, 1'b0, 1'b0);   // accepted at E0
        ref_mem[5] = 32'h32;
        @(negedge clk);                                        // after E0
        n_checks++;
        if ({m_psel, busy} !== 2'b01) begin
            n_fail++; $display("FAIL zw_after_e0 got psel,busy=%b expected 01", {m_psel, busy});
        end
        @(negedge clk);                                        // after E1: SETUP
        n_checks++;
        if ({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata} !== {3'b101, 32'h14, 32'h32}) begin
            n_fail++;
            $display("FAIL zw_setup got psel=%b pen=%b pw=%b addr=%h wd=%h expected 1 0 1 00000014 00000032",
                     m_psel, m_penable, m_pwrite, m_paddr, m_pwdata);
        end
        @(negedge clk);                                        // after E2: ACCESS
        n_checks++;
        if ({m_psel, m_penable} !== 2'b11) begin
            n_fail++; $display("FAIL zw_access got psel,pen=%b expected 11", {m_psel, m_penable});
        end
        @(negedge clk);                                        // after E3: RESP
        n_checks++;
        if ({rsp_valid, m_psel, m_penable} !== 3'b100) begin
            n_fail++; $display("FAIL zw_resp got rv,psel,pen=%b expected 100", {rsp_valid, m_psel, m_penable});
        end
        @(negedge clk);                                        // after E4: IDLE
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL zw_idle got rv,busy=%b expected 00", {rsp_valid, busy});
        end
        n_checks++;
        if (written[5] !== 1'b1 || smem[5] !== 32'h32) begin
            n_fail++; $display("FAIL zw_slave_reg got %h expected 00000032", smem[5]);
        end
        @(posedge clk); #1;
        send_cmd(1'b0, 32'h14, 32'h0, ref_mem[5], 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_registered_read();
        mode = 1; rsp_ready = 1'b1;
        send_cmd(1'b0, 32'h00, 32'h0, ref_mem[0], 1'b0, 1'b0);
        drain();
        n_checks++;
        if (last_len != 2) begin
            n_fail++; $display("FAIL reg_access_len got %0d expected 2", last_len);
        end
        // Two queued reads: stale pready after the first must not shorten the second.
        send_cmd(1'b0, 32'h00, 32'h0, ref_mem[0], 1'b0, 1'b0);
        send_cmd(1'b0, 32'h04, 32'h0, ref_mem[1], 1'b0, 1'b0);
        drain();
        n_checks++;
        if (last_len != 2) begin
            n_fail++; $display("FAIL reg_second_len got %0d expected 2", last_len);
        end
    endtask

    task automatic test_back_to_back();
        mode = 0; rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send_cmd(1'b0, 32'h20 + 32'(4 * i), 32'h0, ref_mem[8 + i], 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_full got ready,busy=%b expected 01", {cmd_ready, busy});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h34; cmd_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({cmd_ready, rsp_valid, m_psel} !== 3'b010 || rsp_rdata !== ref_mem[8]) begin
                n_fail++;
                $display("FAIL b2b_refuse got ready,rv,psel=%b rdata=%h expected 010 %h",
                         {cmd_ready, rsp_valid, m_psel}, rsp_rdata, ref_mem[8]);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        send_cmd(1'b0, 32'h34, 32'h0, ref_mem[13], 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_timeout();
        mode = 2; rsp_ready = 1'b1;
        send_cmd(1'b0, 32'h08, 32'h0, 32'h0, 1'b1, 1'b1);
        drain();
        n_checks++;
        if (last_len != 8) begin
            n_fail++; $display("FAIL timeout_len got %0d expected 8", last_len);
        end
        mode = 0;
        send_cmd(1'b0, 32'h08, 32'h0, ref_mem[2], 1'b0, 1'b0);
        drain();
        n_checks++;
        if (last_len != 1) begin
            n_fail++; $display("FAIL after_timeout_len got %0d expected 1", last_len);
        end
    endtask

    task automatic test_slverr();
        mode = 0; rsp_ready = 1'b1; err_mode = 1'b1;
        send_cmd(1'b0, 32'h0C, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        drain();
        err_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int psel_cnt = 0;
        mode = 2; rsp_ready = 1'b1;
        send_cmd(1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1'b1);
        send_cmd(1'b0, 32'h04, 32'h0, 32'h0, 1'b1, 1'b1);
        send_cmd(1'b0, 32'h08, 32'h0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_psel && m_penable) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL rst_mid_no_access got penable=0 expected 1");
        end
        #1 rstn = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if ({m_psel, m_penable, cmd_ready, busy, rsp_valid} !== 5'b00100) begin
            n_fail++;
            $display("FAIL rst_mid got psel,pen,ready,busy,rv=%b expected 00100",
                     {m_psel, m_penable, cmd_ready, busy, rsp_valid});
        end
        mode = 0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_psel || busy) psel_cnt++;
        end
        n_checks++;
        if (psel_cnt != 0) begin
            n_fail++; $display("FAIL rst_mid_spurious got %0d active cycles expected 0", psel_cnt);
        end
        @(posedge clk); #1;
        send_cmd(1'b0, 32'h04, 32'h0, ref_mem[1], 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        rstn = 1'b0; s_init = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        s_init = 1'b0;
        rstn = 1'b1;
        test_reset();
        test_zero_wait_write();
        test_registered_read();
        test_back_to_back();
        test_timeout();
        test_slverr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
